// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between two
// valid/ready requesters and parks each result in a tagged response slot.
module alu_share_arbiter #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_LEN-1:0] req0_a,
  input  logic [DATA_LEN-1:0] req0_b,
  input  logic [3:0]          req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_LEN-1:0] req1_a,
  input  logic [DATA_LEN-1:0] req1_b,
  input  logic [3:0]          req1_op,
  output logic [DATA_LEN-1:0] alu_a,
  output logic [DATA_LEN-1:0] alu_b,
  output logic [3:0]          alu_op,
  input  logic [DATA_LEN-1:0] alu_result,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_LEN-1:0] rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic [DATA_LEN-1:0] a_q, a_d;
  logic [DATA_LEN-1:0] b_q, b_d;
  logic [3:0]          op_q, op_d;
  logic                id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_LEN-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;

  logic grant_id;
  logic accept;
  logic op_bad;

  // A new operation can be taken in IDLE, or in RESP when the slot drains this cycle.
  always_comb begin
    grant_id = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
    accept   = rst_n && (req0_valid || req1_valid) &&
               ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_bad = 1'b0;
      default:                                     op_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: state_d = IDLE;
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = op_bad;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d       = grant_id ? req1_a  : req0_a;
      b_d       = grant_id ? req1_b  : req0_b;
      op_d      = grant_id ? req1_op : req0_op;
      id_d      = grant_id;
      rr_last_d = grant_id;
      state_d   = EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_last_q    <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The ALU sees the operand registers directly, so it holds the last op between issues.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table plus hand-written
// corner sequences, with a response scoreboard fed at request acceptance.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_op;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [W-1:0] rsp_result;

  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
    logic         err;
  } exp_t;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] exp_result;
    logic         exp_zero;
    logic         exp_err;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter #(.DATA_LEN(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Stand-in for the shared ALU: AND, OR, ADD, SUB, signed SLT; anything else yields 0.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input logic id, input logic [W-1:0] res, input logic z, input logic e);
    exp_t x;
    x.id = id; x.result = res; x.zero = z; x.err = e;
    sb.push_back(x);
  endtask

  task automatic setReq(input logic id, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] op);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Scoreboard consumer: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        checkOutput("rsp_id", rsp_id, x.id);
        checkOutput("rsp_result", rsp_result, x.result);
        checkOutput("rsp_zero", rsp_zero, x.zero);
        checkOutput("rsp_err", rsp_err, x.err);
      end
    end
  end

  // Drives one vector on its requester, holds it until accepted, then withdraws it.
  task automatic applyStimulus(input vec_t v);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    setReq(v.id, 1'b1, v.a, v.b, v.op);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((v.id ? req1_ready : req0_ready) === 1'b1) begin
        pushExp(v.id, v.exp_result, v.exp_zero, v.exp_err);
        ok = 1;
        break;
      end
    end
    checkOutput("vec_accepted", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    setReq(v.id, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   last_acc;
    bit   seen;

    vecs[0] = '{1'b0, 32'd7, 32'd5, 4'b0110, 32'd2, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'd3, 32'd9, 4'b0111, 32'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'd9, 32'd3, 4'b0111, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0000F0F0, 32'h00000FF0, 4'b0000, 32'h000000F0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000F000, 32'h0000000F, 4'b0001, 32'h0000F00F, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'd4, 32'd4, 4'b1111, 32'd0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'd5, 32'd5, 4'b0110, 32'd0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0};

    rst_n = 1'b0;
    rsp_ready = 1'b1;
    setReq(1'b0, 1'b0, '0, '0, '0);
    setReq(1'b1, 1'b0, '0, '0, '0);

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_alu_a", alu_a, '0);
    checkOutput("reset_alu_op", alu_op, '0);
    checkOutput("reset_rsp_result", rsp_result, '0);
    rst_n = 1'b1;

    // Reset asserted during EXEC drops the operation and clears everything at once.
    @(posedge clk); #1;
    setReq(1'b1, 1'b1, 32'd4, 32'd4, 4'b0010);
    @(negedge clk);
    checkOutput("midexec_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    checkOutput("midexec_busy", busy, 1'b1);
    checkOutput("midexec_alu_a", alu_a, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_alu_a", alu_a, '0);
    checkOutput("abort_alu_b", alu_b, '0);
    checkOutput("abort_alu_op", alu_op, '0);
    checkOutput("abort_rsp_valid", rsp_valid, 1'b0);
    checkOutput("abort_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention: both held valid, grants must alternate starting with req0.
    setReq(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
    setReq(1'b1, 1'b1, 32'd3, 32'd9, 4'b0111);
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
          seen = 1;
          break;
        end
      end
      checkOutput("contend_grant_seen", {31'd0, seen}, 32'd1);
      checkOutput("contend_req0_ready", req0_ready, (g % 2 == 0));
      checkOutput("contend_req1_ready", req1_ready, (g % 2 == 1));
      if (g % 2 == 0) pushExp(1'b0, 32'd2, 1'b0, 1'b0);
      else            pushExp(1'b1, 32'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    setReq(1'b0, 1'b0, '0, '0, '0);
    setReq(1'b1, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);

    // Single op latency: accepted at edge N, response visible after edge N+1.
    #1;
    setReq(1'b0, 1'b1, 32'd7, 32'd5, 4'b0110);
    @(negedge clk);
    checkOutput("single_req0_ready", req0_ready, 1'b1);
    pushExp(1'b0, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    setReq(1'b0, 1'b0, '0, '0, '0);
    checkOutput("single_exec_busy", busy, 1'b1);
    checkOutput("single_exec_rsp_valid", rsp_valid, 1'b0);
    checkOutput("single_exec_alu_a", alu_a, 32'd7);
    checkOutput("single_exec_alu_b", alu_b, 32'd5);
    checkOutput("single_exec_alu_op", alu_op, 32'd6);
    @(posedge clk); #1;
    checkOutput("single_rsp_valid", rsp_valid, 1'b1);
    checkOutput("single_rsp_result", rsp_result, 32'd2);
    @(posedge clk); #1;
    checkOutput("single_done_rsp_valid", rsp_valid, 1'b0);
    checkOutput("single_done_busy", busy, 1'b0);
    checkOutput("single_idle_alu_a_held", alu_a, 32'd7);

    // Backpressure: slot and ALU inputs hold while the consumer stalls.
    rsp_ready = 1'b0;
    setReq(1'b0, 1'b1, 32'd10, 32'd3, 4'b0110);
    @(negedge clk);
    checkOutput("bp_req0_ready", req0_ready, 1'b1);
    pushExp(1'b0, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    setReq(1'b0, 1'b0, '0, '0, '0);
    setReq(1'b1, 1'b1, 32'd2, 32'd8, 4'b0111);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", rsp_valid, 1'b1);
      checkOutput("bp_rsp_result", rsp_result, 32'd7);
      checkOutput("bp_rsp_id", rsp_id, 1'b0);
      checkOutput("bp_req0_ready", req0_ready, 1'b0);
      checkOutput("bp_req1_ready", req1_ready, 1'b0);
      checkOutput("bp_busy", busy, 1'b1);
      checkOutput("bp_alu_a_held", alu_a, 32'd10);
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_req1_ready", req1_ready, 1'b1);
    pushExp(1'b1, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    setReq(1'b1, 1'b0, '0, '0, '0);
    checkOutput("bp_release_rsp_valid", rsp_valid, 1'b0);
    checkOutput("bp_release_busy", busy, 1'b1);
    repeat (3) @(posedge clk);

    // Back-to-back: req1 always valid, one acceptance every second cycle.
    #1;
    last_acc = -1;
    setReq(1'b1, 1'b1, 32'd1, 32'd2, 4'b0010);
    for (int k = 0; k < 6; k++) begin
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (req1_ready === 1'b1) begin
          seen = 1;
          break;
        end
      end
      checkOutput("b2b_accept_seen", {31'd0, seen}, 32'd1);
      pushExp(1'b1, 32'(k + 3), 1'b0, 1'b0);
      if (last_acc >= 0) checkOutput("b2b_gap", 32'(cyc - last_acc), 32'd2);
      last_acc = cyc;
      @(posedge clk); #1;
      if (k < 5) setReq(1'b1, 1'b1, 32'(k + 2), 32'd2, 4'b0010);
      else       setReq(1'b1, 1'b0, '0, '0, '0);
    end
    repeat (3) @(posedge clk);

    // Table-driven single-requester vectors, including the unsupported opcode.
    for (int v = 0; v < 10; v++) applyStimulus(vecs[v]);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
